ring_nic: RTL and testbench

- Network interface controller between one processing element and the PE port of a cardinal ring router.
- Buffers processor-written packets in an injection FIFO and hands them to the router's PE input channel only on the cycle whose polarity matches the packet's VC bit.
- Buffers packets ejected on the router's PE output channel in an ejection FIFO for the processor to read.
- Exposes a 4-word memory-mapped register interface to the processor.

---
 rtl/nic_pkg.sv | 23 ++
 rtl/nic_fifo.sv | 64 ++++++
 rtl/ring_nic.sv | 132 +++++++++++++
 tb/tb_ring_nic.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nic_pkg
// Description : Shared constants for the ring NIC: packet width, default
//               virtual-channel bit and processor register addresses.
// Revision    : 1.0 - initial release
// ============================================================================
package nic_pkg;

    // Packet width on both router channels and the processor data bus
    localparam int PKT_W = 64;

    // Default packet bit selecting the even (0) / odd (1) virtual channel
    localparam int NIC_VC_BIT = 63;

    // Processor register map
    localparam logic [1:0] NIC_EJ_DATA  = 2'b00;
    localparam logic [1:0] NIC_EJ_STAT  = 2'b01;
    localparam logic [1:0] NIC_INJ_DATA = 2'b10;
    localparam logic [1:0] NIC_INJ_STAT = 2'b11;

endpackage
`default_nettype wire

// File: rtl/nic_fifo.sv
`default_nettype none
// ============================================================================
// Module      : nic_fifo
// Description : Circular packet FIFO with registered occupancy count. The head
//               output reads 0 when empty. Push when full and pop when empty
//               are ignored. Storage is not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module nic_fifo #(
    parameter int DEPTH = 4,
    parameter int PKT_W = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [PKT_W-1:0]           din,
    output logic [PKT_W-1:0]           dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] c_depth_cnt = (PTR_W+1)'(DEPTH);

    logic [PKT_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_count == c_depth_cnt);
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;
    assign dout   = empty ? '0 : r_mem[r_rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Packet storage write port; contents are don't-care until pushed
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/ring_nic.sv
`default_nettype none
// ============================================================================
// Module      : ring_nic
// Description : Network interface between a processing element and the PE
//               port of a cardinal ring router. Injection FIFO releases its
//               head only on a cycle whose polarity matches the packet VC bit;
//               ejection FIFO buffers router output for processor reads.
// Revision    : 1.0 - initial release
// ============================================================================
module ring_nic
    import nic_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int VC_BIT = NIC_VC_BIT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             nic_en,
    input  logic             nic_wr_en,
    input  logic [1:0]       addr,
    input  logic [PKT_W-1:0] d_in,
    output logic [PKT_W-1:0] d_out,
    input  logic             net_polarity,
    output logic             net_so,
    input  logic             net_ro,
    output logic [PKT_W-1:0] net_do,
    input  logic             net_si,
    output logic             net_ri,
    input  logic [PKT_W-1:0] net_di
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PKT_W-1:0] w_inj_head;
    logic [PTR_W:0]   w_inj_count;
    logic             w_inj_full;
    logic             w_inj_empty;
    logic             w_inj_push;
    logic             w_inj_wr;
    logic             w_inj_stat_rd;

    logic [PKT_W-1:0] w_ej_head;
    logic [PTR_W:0]   w_ej_count;
    logic             w_ej_full;
    logic             w_ej_empty;
    logic             w_ej_push;
    logic             w_ej_pop;

    logic             r_inj_ovf;
    logic [PKT_W-1:0] w_rd_data;

    // Processor register decode
    assign w_inj_wr      = nic_en & nic_wr_en & (addr == NIC_INJ_DATA);
    assign w_inj_push    = w_inj_wr & ~w_inj_full;
    assign w_inj_stat_rd = nic_en & ~nic_wr_en & (addr == NIC_INJ_STAT);
    assign w_ej_pop      = nic_en & ~nic_wr_en & (addr == NIC_EJ_DATA) & ~w_ej_empty;

    // Router side: send only when the head VC matches this cycle's polarity
    assign net_do    = w_inj_head;
    assign net_so    = ~w_inj_empty & net_ro & (w_inj_head[VC_BIT] == net_polarity);
    assign net_ri    = ~w_ej_full;
    assign w_ej_push = net_si & net_ri;

    nic_fifo #(
        .DEPTH (DEPTH),
        .PKT_W (PKT_W)
    ) u_inj_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_inj_push),
        .pop   (net_so),
        .din   (d_in),
        .dout  (w_inj_head),
        .count (w_inj_count),
        .full  (w_inj_full),
        .empty (w_inj_empty)
    );

    nic_fifo #(
        .DEPTH (DEPTH),
        .PKT_W (PKT_W)
    ) u_ej_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_ej_push),
        .pop   (w_ej_pop),
        .din   (net_di),
        .dout  (w_ej_head),
        .count (w_ej_count),
        .full  (w_ej_full),
        .empty (w_ej_empty)
    );

    // Sticky overflow: set by a dropped injection write, cleared by a status read
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_inj_ovf <= 1'b0;
        end else if (w_inj_wr & w_inj_full) begin
            r_inj_ovf <= 1'b1;
        end else if (w_inj_stat_rd) begin
            r_inj_ovf <= 1'b0;
        end
    end

    // Combinational read mux; idle bus reads as zero
    always_comb begin
        w_rd_data = '0;
        if (nic_en) begin
            case (addr)
                NIC_EJ_DATA: begin
                    w_rd_data = w_ej_head;
                end
                NIC_EJ_STAT: begin
                    w_rd_data[0]         = ~w_ej_empty;
                    w_rd_data[PTR_W+1:1] = w_ej_count;
                end
                NIC_INJ_STAT: begin
                    w_rd_data[0]         = w_inj_full;
                    w_rd_data[1]         = r_inj_ovf;
                    w_rd_data[PTR_W+2:2] = w_inj_count;
                end
                default: begin
                    w_rd_data = '0;
                end
            endcase
        end
    end

    assign d_out = w_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_ring_nic.sv
`default_nettype none
// ============================================================================
// Module      : tb_ring_nic
// Description : Self-checking bench for ring_nic: hand-computed vector table,
//               directed ordering and reset sequences, and randomized traffic
//               against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ring_nic;

    localparam int DEPTH = 4;
    localparam int VC    = 63;

    logic        clk = 1'b0;
    logic        reset;
    logic        nic_en;
    logic        nic_wr_en;
    logic [1:0]  addr;
    logic [63:0] d_in;
    logic [63:0] d_out;
    logic        net_polarity;
    logic        net_so;
    logic        net_ro;
    logic [63:0] net_do;
    logic        net_si;
    logic        net_ri;
    logic [63:0] net_di;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [63:0] inj_q[$];
    logic [63:0] ej_q[$];
    bit          ovf_m;
    logic [63:0] sent_q[$];

    typedef struct {
        bit          pol;
        bit          ro;
        bit          en;
        bit          wr;
        logic [1:0]  a;
        logic [63:0] din;
        bit          si;
        logic [63:0] di;
        bit          e_so;
        logic [63:0] e_do;
        bit          e_ri;
        logic [63:0] e_dout;
    } vec_t;

    vec_t tbl[25];

    localparam logic [63:0] P1 = 64'h8000_0000_0000_0011;
    localparam logic [63:0] P2 = 64'h0000_0000_0000_0022;
    localparam logic [63:0] P3 = 64'h8000_0000_0000_0033;
    localparam logic [63:0] P4 = 64'h0000_0000_0000_0044;
    localparam logic [63:0] P5 = 64'h8000_0000_0000_0055;
    localparam logic [63:0] E1 = 64'hC0DE_0000_0000_0001;
    localparam logic [63:0] E2 = 64'hC0DE_0000_0000_0002;
    localparam logic [63:0] E3 = 64'hC0DE_0000_0000_0003;
    localparam logic [63:0] E4 = 64'hC0DE_0000_0000_0004;
    localparam logic [63:0] E5 = 64'hC0DE_0000_0000_0005;

    ring_nic #(.DEPTH(DEPTH), .VC_BIT(VC)) dut (
        .clk          (clk),
        .reset        (reset),
        .nic_en       (nic_en),
        .nic_wr_en    (nic_wr_en),
        .addr         (addr),
        .d_in         (d_in),
        .d_out        (d_out),
        .net_polarity (net_polarity),
        .net_so       (net_so),
        .net_ro       (net_ro),
        .net_do       (net_do),
        .net_si       (net_si),
        .net_ri       (net_ri),
        .net_di       (net_di)
    );

    always #5 clk = ~clk;

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(bit pol, bit ro, bit en, bit wr, logic [1:0] a,
                                logic [63:0] din, bit si, logic [63:0] di,
                                bit e_so, logic [63:0] e_do, bit e_ri, logic [63:0] e_dout);
        vec_t v;
        v.pol = pol; v.ro = ro; v.en = en; v.wr = wr; v.a = a; v.din = din;
        v.si = si; v.di = di; v.e_so = e_so; v.e_do = e_do; v.e_ri = e_ri; v.e_dout = e_dout;
        return v;
    endfunction

    // Expected read data from the register map and the model queues
    function automatic logic [63:0] m_dout();
        logic [63:0] r;
        r = '0;
        if (nic_en) begin
            case (addr)
                2'b00: r = (ej_q.size() != 0) ? ej_q[0] : 64'h0;
                2'b01: r = (64'(ej_q.size()) << 1) | 64'(ej_q.size() != 0);
                2'b10: r = 64'h0;
                default: r = 64'(inj_q.size() == DEPTH) | (64'(ovf_m) << 1)
                             | (64'(inj_q.size()) << 2);
            endcase
        end
        return r;
    endfunction

    // Compare DUT against the model for this cycle, then advance the model
    task automatic model_cycle();
        bit exp_so;
        bit inj_full;
        bit exp_ri;
        exp_so   = (inj_q.size() != 0) && net_ro && (inj_q[0][VC] == net_polarity);
        inj_full = (inj_q.size() == DEPTH);
        exp_ri   = (ej_q.size() < DEPTH);
        chk1("model_so", net_so, exp_so);
        chk64("model_do", net_do, (inj_q.size() != 0) ? inj_q[0] : 64'h0);
        chk1("model_ri", net_ri, exp_ri);
        chk64("model_dout", d_out, m_dout());
        if (net_so) sent_q.push_back(net_do);
        if (exp_so) void'(inj_q.pop_front());
        if (nic_en && nic_wr_en && addr == 2'b10) begin
            if (!inj_full) inj_q.push_back(d_in);
            else           ovf_m = 1'b1;
        end
        if (nic_en && !nic_wr_en && addr == 2'b11) ovf_m = 1'b0;
        if (nic_en && !nic_wr_en && addr == 2'b00 && ej_q.size() != 0) void'(ej_q.pop_front());
        if (net_si && exp_ri) ej_q.push_back(net_di);
    endtask

    // One clock: check at the falling edge, then move past the rising edge
    task automatic step();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        nic_en = 0; nic_wr_en = 0; addr = 2'b00; d_in = '0;
        net_si = 0; net_di = '0;
    endtask

    initial begin
        reset = 0; net_polarity = 0; net_ro = 0;
        idle_inputs();

        // Reset state
        #2;
        chk1("rst_so", net_so, 1'b0);
        chk1("rst_ri", net_ri, 1'b1);
        chk64("rst_do", net_do, 64'h0);
        chk64("rst_dout_idle", d_out, 64'h0);
        nic_en = 1; addr = 2'b11; #1;
        chk64("rst_inj_stat", d_out, 64'h0);
        nic_en = 0;
        #9 reset = 1;
        @(posedge clk); #1;

        // Hand-computed vector table
        tbl[0]  = mk(0,0,0,0,2'b00,64'h0 ,0,64'h0, 0,64'h0 ,1,64'h0);
        tbl[1]  = mk(1,1,1,1,2'b10,64'hAA,0,64'h0, 0,64'h0 ,1,64'h0);
        tbl[2]  = mk(1,1,1,0,2'b11,64'h0 ,0,64'h0, 0,64'hAA,1,64'h4);
        tbl[3]  = mk(0,1,1,0,2'b11,64'h0 ,0,64'h0, 1,64'hAA,1,64'h4);
        tbl[4]  = mk(1,1,1,0,2'b11,64'h0 ,0,64'h0, 0,64'h0 ,1,64'h0);
        tbl[5]  = mk(0,0,1,1,2'b10,P1    ,0,64'h0, 0,64'h0 ,1,64'h0);
        tbl[6]  = mk(1,0,1,1,2'b10,P2    ,0,64'h0, 0,P1    ,1,64'h0);
        tbl[7]  = mk(0,0,1,1,2'b10,P3    ,0,64'h0, 0,P1    ,1,64'h0);
        tbl[8]  = mk(1,0,1,1,2'b10,P4    ,0,64'h0, 0,P1    ,1,64'h0);
        tbl[9]  = mk(0,0,1,1,2'b10,P5    ,0,64'h0, 0,P1    ,1,64'h0);
        tbl[10] = mk(1,0,1,0,2'b11,64'h0 ,0,64'h0, 0,P1    ,1,64'h13);
        tbl[11] = mk(0,0,1,0,2'b11,64'h0 ,0,64'h0, 0,P1    ,1,64'h11);
        tbl[12] = mk(1,0,0,0,2'b00,64'h0 ,1,E1   , 0,P1    ,1,64'h0);
        tbl[13] = mk(0,0,0,0,2'b00,64'h0 ,1,E2   , 0,P1    ,1,64'h0);
        tbl[14] = mk(1,0,0,0,2'b00,64'h0 ,1,E3   , 0,P1    ,1,64'h0);
        tbl[15] = mk(0,0,0,0,2'b00,64'h0 ,1,E4   , 0,P1    ,1,64'h0);
        tbl[16] = mk(1,0,1,0,2'b00,64'h0 ,0,64'h0, 0,P1    ,0,E1);
        tbl[17] = mk(0,0,1,0,2'b01,64'h0 ,0,64'h0, 0,P1    ,1,64'h7);
        tbl[18] = mk(1,0,1,0,2'b00,64'h0 ,0,64'h0, 0,P1    ,1,E2);
        tbl[19] = mk(0,0,1,0,2'b00,64'h0 ,1,E5   , 0,P1    ,1,E3);
        tbl[20] = mk(1,0,1,0,2'b01,64'h0 ,0,64'h0, 0,P1    ,1,64'h5);
        tbl[21] = mk(0,0,1,0,2'b00,64'h0 ,0,64'h0, 0,P1    ,1,E4);
        tbl[22] = mk(1,0,1,0,2'b00,64'h0 ,0,64'h0, 0,P1    ,1,E5);
        tbl[23] = mk(0,0,1,0,2'b00,64'h0 ,0,64'h0, 0,P1    ,1,64'h0);
        tbl[24] = mk(1,0,1,0,2'b01,64'h0 ,0,64'h0, 0,P1    ,1,64'h0);

        for (int i = 0; i < 25; i++) begin
            net_polarity = tbl[i].pol; net_ro = tbl[i].ro;
            nic_en = tbl[i].en; nic_wr_en = tbl[i].wr; addr = tbl[i].a; d_in = tbl[i].din;
            net_si = tbl[i].si; net_di = tbl[i].di;
            @(negedge clk);
            chk1($sformatf("tbl%0d_so", i), net_so, tbl[i].e_so);
            chk64($sformatf("tbl%0d_do", i), net_do, tbl[i].e_do);
            chk1($sformatf("tbl%0d_ri", i), net_ri, tbl[i].e_ri);
            chk64($sformatf("tbl%0d_dout", i), d_out, tbl[i].e_dout);
            model_cycle();
            @(posedge clk); #1;
        end

        // Ordering: P1..P4 queued (VC 1,0,1,0); drain with toggling polarity
        idle_inputs();
        sent_q.delete();
        net_ro = 1; net_polarity = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (net_so) chk1("order_vc_match", net_do[VC], net_polarity);
            model_cycle();
            @(posedge clk); #1;
            net_polarity = ~net_polarity;
        end
        chk64("order_count", 64'(sent_q.size()), 64'd4);
        if (sent_q.size() == 4) begin
            chk64("order_p1", sent_q[0], P1);
            chk64("order_p2", sent_q[1], P2);
            chk64("order_p3", sent_q[2], P3);
            chk64("order_p4", sent_q[3], P4);
        end

        // Reset mid-stream with three injection and two ejection packets queued
        net_ro = 0;
        for (int k = 0; k < 3; k++) begin
            nic_en = 1; nic_wr_en = 1; addr = 2'b10; d_in = 64'h0000_0000_0000_0100 + 64'(k);
            net_si = (k < 2); net_di = 64'hBEEF_0000_0000_0000 + 64'(k);
            step();
        end
        idle_inputs();
        net_ro = 1; net_polarity = 0;
        @(negedge clk);
        reset = 0;
        #1;
        chk1("mid_rst_so", net_so, 1'b0);
        chk1("mid_rst_ri", net_ri, 1'b1);
        chk64("mid_rst_do", net_do, 64'h0);
        nic_en = 1; addr = 2'b11; #1;
        chk64("mid_rst_inj_stat", d_out, 64'h0);
        addr = 2'b01; #1;
        chk64("mid_rst_ej_stat", d_out, 64'h0);
        idle_inputs();
        inj_q.delete(); ej_q.delete(); ovf_m = 0;
        @(posedge clk); #2;
        reset = 1;
        @(posedge clk); #1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk1("post_rst_no_send", net_so, 1'b0);
            model_cycle();
            @(posedge clk); #1;
            net_polarity = ~net_polarity;
        end

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            nic_en    = ($urandom_range(0, 3) != 0);
            nic_wr_en = $urandom_range(0, 1);
            addr      = 2'($urandom_range(0, 3));
            d_in      = {$urandom, $urandom};
            net_ro    = (c < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            net_si    = $urandom_range(0, 1);
            net_di    = {$urandom, $urandom};
            step();
            net_polarity = ~net_polarity;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
